// File: rtl/pipe_decode_fwd_if.sv
// Decode-stage bundle: D-register fields, forwarding/write-back sources and the E-register image.
// Instruction handshake: a D instruction is consumed at a rising edge when d_valid=1 and d_stall=0;
// while d_stall=1 the upstream stage holds its D fields unchanged.
interface pipe_decode_fwd_if #(
    parameter int XLEN = 64
);
    logic            d_valid;
    logic [3:0]      d_icode, d_ifun, d_rA, d_rB;
    logic [XLEN-1:0] d_valC, d_valP;

    logic [3:0]      e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
    logic [XLEN-1:0] e_valE, M_valE, m_valM, W_valE, W_valM;

    logic [3:0]      E_dstM_cur;
    logic            e_bubble;

    logic            d_stall;
    logic            E_valid;
    logic [3:0]      E_icode, E_ifun;
    logic [XLEN-1:0] E_valC, E_valA, E_valB;
    logic [3:0]      E_dstE, E_dstM, E_srcA, E_srcB;
    logic [15:0]     stall_cnt;

    modport master (
        output d_valid, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
        output e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        output W_dstE, W_valE, W_dstM, W_valM, E_dstM_cur, e_bubble,
        input  d_stall, E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB, stall_cnt
    );

    modport slave (
        input  d_valid, d_icode, d_ifun, d_rA, d_rB, d_valC, d_valP,
        input  e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM,
        input  W_dstE, W_valE, W_dstM, W_valM, E_dstM_cur, e_bubble,
        output d_stall, E_valid, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB, stall_cnt
    );
endinterface

// File: rtl/pipe_decode_fwd.sv
// Y86-style decode stage: register file, operand forwarding, load-use stall and the E pipeline register.
module pipe_decode_fwd #(
    parameter int XLEN = 64,
    parameter int NREG = 15,
    parameter int RSP  = 4
) (
    input logic clk,
    input logic rst,
    pipe_decode_fwd_if.slave bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] NREG4 = 4'(NREG);
    localparam logic [3:0] RSP4  = 4'(RSP);
    localparam logic [3:0] INOP  = 4'd1;

    logic [XLEN-1:0] rf [NREG];

    logic [3:0]      srcA, srcB, dstE, dstM;
    logic [XLEN-1:0] valA, valB;
    logic            usesValP;
    logic            hazard;
    logic            loadBubble;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (bus.d_icode)
            4'd2, 4'd4, 4'd6, 4'd10: srcA = bus.d_rA;
            4'd9, 4'd11:             srcA = RSP4;
            default: ;
        endcase
        case (bus.d_icode)
            4'd4, 4'd5, 4'd6:            srcB = bus.d_rB;
            4'd8, 4'd9, 4'd10, 4'd11:    srcB = RSP4;
            default: ;
        endcase
        case (bus.d_icode)
            4'd2, 4'd3, 4'd6:            dstE = bus.d_rB;
            4'd8, 4'd9, 4'd10, 4'd11:    dstE = RSP4;
            default: ;
        endcase
        case (bus.d_icode)
            4'd5, 4'd11: dstM = bus.d_rA;
            default: ;
        endcase
    end

    // Youngest producer wins; RNONE never matches, and indices past NREG read as zero.
    function automatic logic [XLEN-1:0] operand(input logic [3:0] src);
        if (src == RNONE)       return '0;
        if (src == bus.e_dstE)  return bus.e_valE;
        if (src == bus.M_dstM)  return bus.m_valM;
        if (src == bus.M_dstE)  return bus.M_valE;
        if (src == bus.W_dstM)  return bus.W_valM;
        if (src == bus.W_dstE)  return bus.W_valE;
        if (src < NREG4)        return rf[src];
        return '0;
    endfunction

    always_comb begin
        usesValP = (bus.d_icode == 4'd7) || (bus.d_icode == 4'd8);
        valA     = usesValP ? bus.d_valP : operand(srcA);
        valB     = operand(srcB);
    end

    always_comb begin
        hazard = bus.d_valid && (bus.E_dstM_cur != RNONE) &&
                 (((bus.E_dstM_cur == srcA) && !usesValP) || (bus.E_dstM_cur == srcB));
        bus.d_stall = hazard && !bus.e_bubble;
        loadBubble  = bus.e_bubble || hazard || !bus.d_valid;
    end

    always_ff @(posedge clk) begin
        if (rst || loadBubble) begin
            bus.E_valid <= 1'b0;
            bus.E_icode <= INOP;
            bus.E_ifun  <= 4'd0;
            bus.E_valC  <= '0;
            bus.E_valA  <= '0;
            bus.E_valB  <= '0;
            bus.E_dstE  <= RNONE;
            bus.E_dstM  <= RNONE;
            bus.E_srcA  <= RNONE;
            bus.E_srcB  <= RNONE;
        end else begin
            bus.E_valid <= 1'b1;
            bus.E_icode <= bus.d_icode;
            bus.E_ifun  <= bus.d_ifun;
            bus.E_valC  <= bus.d_valC;
            bus.E_valA  <= valA;
            bus.E_valB  <= valB;
            bus.E_dstE  <= dstE;
            bus.E_dstM  <= dstM;
            bus.E_srcA  <= srcA;
            bus.E_srcB  <= srcB;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bus.stall_cnt <= '0;
        else if (bus.d_stall && (bus.stall_cnt != 16'hFFFF))
            bus.stall_cnt <= bus.stall_cnt + 16'd1;
    end

    // The dstM write is issued second so a load result beats an ALU result to the same register.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) rf[i] <= '0;
        end else begin
            if (bus.W_dstE < NREG4) rf[bus.W_dstE] <= bus.W_valE;
            if (bus.W_dstM < NREG4) rf[bus.W_dstM] <= bus.W_valM;
        end
    end
endmodule

// File: tb/tb_pipe_decode_fwd.sv
// Randomized and directed bench for pipe_decode_fwd against a list-based reference model.
module tb_pipe_decode_fwd;
  localparam int XLEN = 64;
  localparam int NREG = 15;
  localparam int RSP  = 4;
  localparam logic [3:0] RN = 4'hF;
  localparam int EW = 1 + 4 + 4 + 3 * 64 + 4 * 4;

  logic clk;
  logic rst;
  int checks = 0;
  int errors = 0;

  pipe_decode_fwd_if #(.XLEN(XLEN)) bus ();

  pipe_decode_fwd #(.XLEN(XLEN), .NREG(NREG), .RSP(RSP)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [63:0] mrf [16];
  logic [15:0] m_cnt;
  logic [EW-1:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] m_srcA(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'd2, 4'd4, 4'd6, 4'd10}) return ra;
    if (ic inside {4'd9, 4'd11}) return 4'(RSP);
    return RN;
  endfunction

  function automatic logic [3:0] m_srcB(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'd4, 4'd5, 4'd6}) return rb;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'(RSP);
    return RN;
  endfunction

  function automatic logic [3:0] m_dstE(input logic [3:0] ic, input logic [3:0] rb);
    if (ic inside {4'd2, 4'd3, 4'd6}) return rb;
    if (ic inside {4'd8, 4'd9, 4'd10, 4'd11}) return 4'(RSP);
    return RN;
  endfunction

  function automatic logic [3:0] m_dstM(input logic [3:0] ic, input logic [3:0] ra);
    if (ic inside {4'd5, 4'd11}) return ra;
    return RN;
  endfunction

  function automatic logic [63:0] m_operand(input logic [3:0] src);
    logic [3:0]  dsts [5];
    logic [63:0] vals [5];
    dsts = '{bus.e_dstE, bus.M_dstM, bus.M_dstE, bus.W_dstM, bus.W_dstE};
    vals = '{bus.e_valE, bus.m_valM, bus.M_valE, bus.W_valM, bus.W_valE};
    if (src == RN) return 64'd0;
    for (int k = 0; k < 5; k++)
      if (dsts[k] == src) return vals[k];
    return (int'(src) < NREG) ? mrf[src] : 64'd0;
  endfunction

  // One clock: check the combinational stall, predict E, advance the model, compare after the edge.
  task automatic cycle();
    logic [3:0] sa, sb, de, dm;
    logic hz, bub, stall, pass_p;
    logic [63:0] va, vb;
    logic [EW-1:0] e;
    #1;
    sa = m_srcA(bus.d_icode, bus.d_rA);
    sb = m_srcB(bus.d_icode, bus.d_rB);
    de = m_dstE(bus.d_icode, bus.d_rB);
    dm = m_dstM(bus.d_icode, bus.d_rA);
    pass_p = bus.d_icode inside {4'd7, 4'd8};
    hz = bus.d_valid && bus.E_dstM_cur != RN &&
         ((!pass_p && bus.E_dstM_cur == sa) || bus.E_dstM_cur == sb);
    stall = hz && !bus.e_bubble;
    check("d_stall", 64'(bus.d_stall), 64'(stall));
    va = pass_p ? bus.d_valP : m_operand(sa);
    vb = m_operand(sb);
    bub = rst || bus.e_bubble || hz || !bus.d_valid;
    if (bub) e = {1'b0, 4'd1, 4'd0, 64'd0, 64'd0, 64'd0, RN, RN, RN, RN};
    else     e = {1'b1, bus.d_icode, bus.d_ifun, bus.d_valC, va, vb, de, dm, sa, sb};
    exp_q.push_back(e);
    if (rst) begin
      foreach (mrf[i]) mrf[i] = 64'd0;
      m_cnt = 16'd0;
    end else begin
      if (int'(bus.W_dstE) < NREG) mrf[bus.W_dstE] = bus.W_valE;
      if (int'(bus.W_dstM) < NREG) mrf[bus.W_dstM] = bus.W_valM;
      if (stall && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("E_valid", 64'(bus.E_valid), 64'(e[216]));
    check("E_icode", 64'(bus.E_icode), 64'(e[215:212]));
    check("E_ifun",  64'(bus.E_ifun),  64'(e[211:208]));
    check("E_valC",  bus.E_valC, e[207:144]);
    check("E_valA",  bus.E_valA, e[143:80]);
    check("E_valB",  bus.E_valB, e[79:16]);
    check("E_dstE",  64'(bus.E_dstE), 64'(e[15:12]));
    check("E_dstM",  64'(bus.E_dstM), 64'(e[11:8]));
    check("E_srcA",  64'(bus.E_srcA), 64'(e[7:4]));
    check("E_srcB",  64'(bus.E_srcB), 64'(e[3:0]));
    check("stall_cnt", 64'(bus.stall_cnt), 64'(m_cnt));
  endtask

  // driver tasks
  task automatic drive_idle();
    rst = 1'b0;
    bus.d_valid = 1'b0; bus.d_icode = 4'd1; bus.d_ifun = 4'd0;
    bus.d_rA = RN; bus.d_rB = RN; bus.d_valC = 64'd0; bus.d_valP = 64'd0;
    bus.e_dstE = RN; bus.M_dstE = RN; bus.M_dstM = RN; bus.W_dstE = RN; bus.W_dstM = RN;
    bus.e_valE = 64'd0; bus.M_valE = 64'd0; bus.m_valM = 64'd0; bus.W_valE = 64'd0; bus.W_valM = 64'd0;
    bus.E_dstM_cur = RN; bus.e_bubble = 1'b0;
  endtask

  task automatic drive_insn(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                            input logic [63:0] vc, input logic [63:0] vp);
    bus.d_valid = 1'b1; bus.d_icode = ic; bus.d_ifun = 4'd0;
    bus.d_rA = ra; bus.d_rB = rb; bus.d_valC = vc; bus.d_valP = vp;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 2) == 0) ? RN : 4'($urandom_range(0, 15));
  endfunction

  task automatic drive_random();
    rst = ($urandom_range(0, 29) == 0);
    bus.d_valid = ($urandom_range(0, 3) != 0);
    bus.d_icode = 4'($urandom_range(0, 11));
    bus.d_ifun  = 4'($urandom_range(0, 15));
    bus.d_rA = 4'($urandom_range(0, 15));
    bus.d_rB = 4'($urandom_range(0, 15));
    bus.d_valC = {$urandom, $urandom};
    bus.d_valP = {$urandom, $urandom};
    bus.e_dstE = rnd_reg(); bus.M_dstE = rnd_reg(); bus.M_dstM = rnd_reg();
    bus.W_dstE = rnd_reg(); bus.W_dstM = rnd_reg();
    bus.e_valE = {$urandom, $urandom}; bus.M_valE = {$urandom, $urandom};
    bus.m_valM = {$urandom, $urandom}; bus.W_valE = {$urandom, $urandom};
    bus.W_valM = {$urandom, $urandom};
    case ($urandom_range(0, 3))
      0: bus.E_dstM_cur = bus.d_rA;
      1: bus.E_dstM_cur = bus.d_rB;
      2: bus.E_dstM_cur = 4'(RSP);
      default: bus.E_dstM_cur = RN;
    endcase
    bus.e_bubble = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    logic [15:0] cnt_before;
    foreach (mrf[i]) mrf[i] = 64'd0;
    m_cnt = 16'd0;

    // reset state
    drive_idle();
    rst = 1'b1;
    cycle();
    check("reset_icode", 64'(bus.E_icode), 64'd1);
    check("reset_cnt", 64'(bus.stall_cnt), 64'd0);

    // register-file path: irmovq then write-back then rrmovq reads it
    drive_idle(); drive_insn(4'd3, RN, 4'd2, 64'h55, 64'd0);
    cycle();
    check("irmovq_dstE", 64'(bus.E_dstE), 64'd2);
    drive_idle(); bus.W_dstE = 4'd2; bus.W_valE = 64'h55;
    cycle();
    drive_idle(); drive_insn(4'd2, 4'd2, 4'd5, 64'd0, 64'd0);
    cycle();
    check("rrmovq_rf", bus.E_valA, 64'h55);

    // forwarding priority
    drive_idle(); drive_insn(4'd6, 4'd1, 4'd3, 64'd0, 64'd0);
    bus.e_dstE = 4'd1; bus.e_valE = 64'd7; bus.M_dstE = 4'd3; bus.M_valE = 64'd9;
    bus.W_dstE = 4'd1; bus.W_valE = 64'd2;
    cycle();
    check("addq_valA", bus.E_valA, 64'd7);
    check("addq_valB", bus.E_valB, 64'd9);

    // load-use stall then forwarded load result
    cnt_before = m_cnt;
    drive_idle(); drive_insn(4'd5, 4'd6, 4'd2, 64'd8, 64'd0); bus.E_dstM_cur = 4'd2;
    cycle();
    check("loaduse_valid", 64'(bus.E_valid), 64'd0);
    check("loaduse_cnt", 64'(bus.stall_cnt), 64'(cnt_before + 16'd1));
    bus.E_dstM_cur = RN; bus.M_dstM = 4'd2; bus.m_valM = 64'hAB;
    cycle();
    check("loaduse_valB", bus.E_valB, 64'hAB);

    // same-index write-back keeps the load value
    drive_idle(); drive_insn(4'd11, 4'd0, RN, 64'd0, 64'd0);
    bus.W_dstE = 4'd4; bus.W_valE = 64'h100; bus.W_dstM = 4'd4; bus.W_valM = 64'h200;
    cycle();
    drive_idle(); drive_insn(4'd10, 4'd4, RN, 64'd0, 64'd0);
    cycle();
    check("popq_wb", bus.E_valA, 64'h200);

    // flush overrides hazard; call passes valP
    drive_idle(); drive_insn(4'd5, 4'd6, 4'd2, 64'd0, 64'd0);
    bus.E_dstM_cur = 4'd2; bus.e_bubble = 1'b1;
    cycle();
    check("flush_icode", 64'(bus.E_icode), 64'd1);
    drive_idle(); drive_insn(4'd8, RN, RN, 64'h1000, 64'h40);
    cycle();
    check("call_valA", bus.E_valA, 64'h40);
    check("call_dstE", 64'(bus.E_dstE), 64'd4);

    // randomized traffic
    for (int n = 0; n < 600; n++) begin
      drive_random();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
